// File: rtl/apu_noise_pkg.sv
// Shared definitions for the APU noise channel: register field layout,
// divisor reload decoding and the LFSR freeze threshold.
package apu_noise_pkg;

    localparam int unsigned WDATA_W         = 8;
    localparam int unsigned ENV_VOL_MSB     = 7;
    localparam int unsigned ENV_UP_BIT      = 3;
    localparam int unsigned ENV_PER_W       = 3;
    localparam int unsigned CTRL_TRIG_BIT   = 7;
    localparam int unsigned CTRL_LEN_EN_BIT = 6;
    localparam int unsigned DIV_CODE_W      = 3;
    localparam int unsigned DIV_CNT_W       = 4;

    // Poly register exactly as laid out on the write bus
    typedef struct packed {
        logic [3:0]            shift;
        logic                  short_mode;
        logic [DIV_CODE_W-1:0] div_code;
    } poly_reg_t;

    // Number of tick_div strobes between divisor expiries
    function automatic logic [DIV_CNT_W-1:0] div_reload(input logic [DIV_CODE_W-1:0] code);
        return (code == '0) ? DIV_CNT_W'(1) : {code, 1'b0};
    endfunction

    // Shift values at or above this stop the LFSR
    function automatic int unsigned freeze_shift(input int unsigned shift_w);
        return (32'd1 << shift_w) - 32'd2;
    endfunction

endpackage

// File: rtl/apu_envelope.sv
// Volume envelope: periodic +/-1 volume steps with saturation, reloaded on trigger.
module apu_envelope #(
    parameter int unsigned AMP_W = 4,
    parameter int unsigned PER_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [AMP_W-1:0] load_vol_i,
    input  logic [PER_W-1:0] load_period_i,
    input  logic             tick_i,
    input  logic             up_i,
    input  logic [PER_W-1:0] period_i,
    output logic [AMP_W-1:0] vol_o
);

    logic [AMP_W-1:0] vol_q, vol_d;
    logic [PER_W-1:0] timer_q, timer_d;

    // Timer countdown and saturating volume step; period 0 freezes the envelope
    always_comb begin
        vol_d   = vol_q;
        timer_d = timer_q;
        if (load_i) begin
            vol_d   = load_vol_i;
            timer_d = load_period_i;
        end else if (tick_i && (period_i != '0)) begin
            if (timer_q <= PER_W'(1)) begin
                timer_d = period_i;
                if (up_i) begin
                    if (vol_q != '1) vol_d = vol_q + AMP_W'(1);
                end else if (vol_q != '0) begin
                    vol_d = vol_q - AMP_W'(1);
                end
            end else begin
                timer_d = timer_q - PER_W'(1);
            end
        end
    end

    // Envelope state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vol_q   <= '0;
            timer_q <= '0;
        end else begin
            vol_q   <= vol_d;
            timer_q <= timer_d;
        end
    end

    assign vol_o = vol_q;

endmodule

// File: rtl/noise_channel_gen.sv
// APU noise channel: prescaled LFSR noise, envelope, length counter, DAC gating.
module noise_channel_gen
    import apu_noise_pkg::*;
#(
    parameter int unsigned LFSR_W  = 15,
    parameter int unsigned SHORT_W = 7,
    parameter int unsigned AMP_W   = 4,
    parameter int unsigned LEN_W   = 6,
    parameter int unsigned SHIFT_W = 4
) (
    input  logic               phi,
    input  logic               napu_reset,
    input  logic               tick_div,
    input  logic               tick_len,
    input  logic               tick_env,
    input  logic               wr_len,
    input  logic               wr_env,
    input  logic               wr_poly,
    input  logic               wr_ctrl,
    input  logic [WDATA_W-1:0] wdata,
    output logic               active,
    output logic               dac_en,
    output logic [AMP_W-1:0]   amp
);

    // Prescaler only needs enough bits for the largest non-frozen shift
    localparam int unsigned PRE_W = (32'd1 << SHIFT_W) - 32'd3;
    localparam logic [SHIFT_W-1:0] FREEZE_SH = SHIFT_W'(freeze_shift(SHIFT_W));

    logic [AMP_W-1:0]     init_vol_q, init_vol_d;
    logic                 env_up_q, env_up_d;
    logic [ENV_PER_W-1:0] env_per_q, env_per_d;
    poly_reg_t            poly_q, poly_d;
    logic                 len_en_q, len_en_d;
    logic [LEN_W-1:0]     len_cnt_q, len_cnt_d;
    logic                 expired_q, expired_d;
    logic [DIV_CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic                 active_q, active_d;
    logic                 dac_en_q, dac_en_d;
    logic [AMP_W-1:0]     amp_q, amp_d;

    logic                 trigger;
    logic                 len_wrap;
    logic [SHIFT_W-1:0]   shift;
    logic [PRE_W-1:0]     pre_mask;
    logic                 lfsr_clk;
    logic [AMP_W-1:0]     vol;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur,
                                                    input logic              short_mode);
        logic              fb;
        logic [LFSR_W-1:0] nxt;
        fb  = ~(cur[0] ^ cur[1]);
        nxt = {fb, cur[LFSR_W-1:1]};
        if (short_mode) nxt[SHORT_W-1] = fb;
        return nxt;
    endfunction

    assign shift    = poly_q.shift[SHIFT_W-1:0];
    assign pre_mask = PRE_W'((32'd1 << shift) - 32'd1);
    assign lfsr_clk = (shift < FREEZE_SH) && ((pre_q & pre_mask) == pre_mask);

    // Register writes; trigger qualifies against the post-write DAC enable
    always_comb begin
        init_vol_d = init_vol_q;
        env_up_d   = env_up_q;
        env_per_d  = env_per_q;
        poly_d     = poly_q;
        len_en_d   = len_en_q;
        if (wr_env) begin
            init_vol_d = wdata[ENV_VOL_MSB -: AMP_W];
            env_up_d   = wdata[ENV_UP_BIT];
            env_per_d  = wdata[ENV_PER_W-1:0];
        end
        if (wr_poly) poly_d = poly_reg_t'(wdata);
        if (wr_ctrl) len_en_d = wdata[CTRL_LEN_EN_BIT];
        dac_en_d = (init_vol_d != '0) || env_up_d;
        trigger  = wr_ctrl && wdata[CTRL_TRIG_BIT] && dac_en_d;
    end

    // Divisor, prescaler and LFSR stepping; a trigger swallows tick_div
    always_comb begin
        div_cnt_d = div_cnt_q;
        pre_d     = pre_q;
        lfsr_d    = lfsr_q;
        if (trigger) begin
            div_cnt_d = div_reload(poly_d.div_code);
            pre_d     = '0;
            lfsr_d    = '0;
        end else if (tick_div) begin
            if (div_cnt_q <= DIV_CNT_W'(1)) begin
                div_cnt_d = div_reload(poly_q.div_code);
                pre_d     = pre_q + PRE_W'(1);
                if (lfsr_clk && active_q) lfsr_d = lfsr_step(lfsr_q, poly_q.short_mode);
            end else begin
                div_cnt_d = div_cnt_q - DIV_CNT_W'(1);
            end
        end
    end

    // Length counter and channel running state
    always_comb begin
        len_cnt_d = len_cnt_q;
        expired_d = expired_q;
        active_d  = active_q;
        len_wrap  = 1'b0;
        if (wr_len) begin
            len_cnt_d = wdata[LEN_W-1:0];
            expired_d = 1'b0;
        end else if (tick_len && len_en_q && !trigger) begin
            len_cnt_d = len_cnt_q + LEN_W'(1);
            if (len_cnt_q == '1) begin
                expired_d = 1'b1;
                len_wrap  = 1'b1;
            end
        end
        if (trigger && expired_d) begin
            len_cnt_d = '0;
            expired_d = 1'b0;
        end
        if (!dac_en_d)    active_d = 1'b0;
        else if (trigger) active_d = 1'b1;
        else if (len_wrap) active_d = 1'b0;
    end

    // Output amplitude from the current state, visible one edge later
    always_comb begin
        amp_d = (active_q && !lfsr_q[0]) ? vol : '0;
    end

    apu_envelope #(
        .AMP_W (AMP_W),
        .PER_W (ENV_PER_W)
    ) u_env (
        .clk_i         (phi),
        .rst_ni        (napu_reset),
        .load_i        (trigger),
        .load_vol_i    (init_vol_d),
        .load_period_i (env_per_d),
        .tick_i        (tick_env && !trigger),
        .up_i          (env_up_q),
        .period_i      (env_per_q),
        .vol_o         (vol)
    );

    // Channel state registers
    always_ff @(posedge phi or negedge napu_reset) begin
        if (!napu_reset) begin
            init_vol_q <= '0;
            env_up_q   <= 1'b0;
            env_per_q  <= '0;
            poly_q     <= '0;
            len_en_q   <= 1'b0;
            len_cnt_q  <= '0;
            expired_q  <= 1'b0;
            div_cnt_q  <= '0;
            pre_q      <= '0;
            lfsr_q     <= '0;
            active_q   <= 1'b0;
            dac_en_q   <= 1'b0;
            amp_q      <= '0;
        end else begin
            init_vol_q <= init_vol_d;
            env_up_q   <= env_up_d;
            env_per_q  <= env_per_d;
            poly_q     <= poly_d;
            len_en_q   <= len_en_d;
            len_cnt_q  <= len_cnt_d;
            expired_q  <= expired_d;
            div_cnt_q  <= div_cnt_d;
            pre_q      <= pre_d;
            lfsr_q     <= lfsr_d;
            active_q   <= active_d;
            dac_en_q   <= dac_en_d;
            amp_q      <= amp_d;
        end
    end

    assign active = active_q;
    assign dac_en = dac_en_q;
    assign amp    = amp_q;

endmodule
